instr_encoder: RTL

Encodes instruction requests into 32-bit machine words and writes them sequentially into instruction memory. It uses the same opcode and funct encodings that the control decoder consumes. The block sits between the test/boot program source and the instruction memory write port. Its job is to assemble and load programs so that the decode path can execute them.

---
 rtl/instr_encoder.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// instr_encoder
// Assembles instruction requests into 32-bit machine words and writes them
// one at a time, at consecutive word addresses, into instruction memory.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               one-cycle pulse: pointer <= base_addr, clears count/err/wrapped
//   base_addr           first word address written after start
//   in_valid/in_ready   request handshake
//   op_sel              operation index (0..26 legal, 27..31 illegal)
//   rs/rt/rd/shamt      register and shift fields
//   imm, target         I-type immediate, J-type target
//   mem_we/mem_ack      write request held until acknowledged
//   mem_addr/mem_wdata  write address and encoded word, stable while mem_we=1
//   count               instructions written since start/reset (saturating)
//   err                 sticky: an illegal op_sel was accepted
//   wrapped             sticky: write pointer wrapped past all-ones
module instr_encoder #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        op_sel,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    output logic [ADDR_W:0]   count,
    output logic              err,
    output logic              wrapped
);

    typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_t;

    localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

    // Returns {legal, word}. Legal=0 for op_sel 27..31.
    function automatic logic [32:0] encode_instr(
        input logic [4:0]  op,
        input logic [4:0]  f_rs,
        input logic [4:0]  f_rt,
        input logic [4:0]  f_rd,
        input logic [4:0]  f_sh,
        input logic [15:0] f_imm,
        input logic [25:0] f_tgt
    );
        logic [32:0] res;
        res = {1'b0, 32'h0000_0000};
        case (op)
            5'd0:  res = {1'b1, 6'b100011, f_rs, f_rt, f_imm};
            5'd1:  res = {1'b1, 6'b101011, f_rs, f_rt, f_imm};
            5'd2:  res = {1'b1, 6'b000010, f_tgt};
            5'd3:  res = {1'b1, 6'b000011, f_tgt};
            5'd4:  res = {1'b1, 6'b000001, f_rs, f_rt, f_imm};
            5'd5:  res = {1'b1, 6'b000100, f_rs, f_rt, f_imm};
            5'd6:  res = {1'b1, 6'b000101, f_rs, f_rt, f_imm};
            5'd7:  res = {1'b1, 6'b001111, f_rs, f_rt, f_imm};
            5'd8:  res = {1'b1, 6'b010000, f_rs, f_rt, f_imm};
            5'd9:  res = {1'b1, 6'b010001, f_rs, f_rt, f_imm};
            5'd10: res = {1'b1, 6'b010010, f_rs, f_rt, f_imm};
            5'd11: res = {1'b1, 6'b010011, f_rs, f_rt, f_imm};
            5'd12: res = {1'b1, 6'b010100, f_rs, f_rt, f_imm};
            5'd13: res = {1'b1, 6'b001100, f_rs, f_rt, f_imm};
            5'd14: res = {1'b1, 6'b001101, f_rs, f_rt, f_imm};
            // R-type: only the shift ops (19, 20, 23, 25) keep shamt
            5'd15: res = {1'b1, 6'b000000, f_rs, f_rt, f_rd, 5'd0, 6'b100000};
            5'd16: res = {1'b1, 6'b000000, f_rs, f_rt, f_rd, 5'd0, 6'b100010};
            5'd17: res = {1'b1, 6'b000000, f_rs, f_rt, f_rd, 5'd0, 6'b101010};
            5'd18: res = {1'b1, 6'b000000, f_rs, f_rt, f_rd, 5'd0, 6'b100100};
            5'd19: res = {1'b1, 6'b000000, f_rs, f_rt, f_rd, f_sh, 6'b011111};
            5'd20: res = {1'b1, 6'b000000, f_rs, f_rt, f_rd, f_sh, 6'b011110};
            5'd21: res = {1'b1, 6'b000000, f_rs, f_rt, f_rd, 5'd0, 6'b100101};
            5'd22: res = {1'b1, 6'b000000, f_rs, f_rt, f_rd, 5'd0, 6'b100110};
            5'd23: res = {1'b1, 6'b000000, f_rs, f_rt, f_rd, f_sh, 6'b011101};
            5'd24: res = {1'b1, 6'b000000, f_rs, f_rt, f_rd, 5'd0, 6'b100111};
            5'd25: res = {1'b1, 6'b000000, f_rs, f_rt, f_rd, f_sh, 6'b101000};
            // jr keeps only rs
            5'd26: res = {1'b1, 6'b000000, f_rs, 5'd0, 5'd0, 5'd0, 6'b001000};
            default: res = {1'b0, 32'h0000_0000};
        endcase
        return res;
    endfunction

    state_t            state_r;
    logic              rdy_r;
    logic [ADDR_W-1:0] ptr_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [31:0]       mem_wdata_r;
    logic [ADDR_W:0]   count_r;
    logic              err_r;
    logic              wrapped_r;
    logic [32:0]       enc_s;

    assign enc_s = encode_instr(op_sel, rs, rt, rd, shamt, imm, target);

    // rdy_r is low in reset and the first cycle after it; start masks acceptance
    assign in_ready  = rdy_r & ~start;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign count     = count_r;
    assign err       = err_r;
    assign wrapped   = wrapped_r;

    // Request/write FSM with all outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            rdy_r       <= 1'b0;
            ptr_r       <= {ADDR_W{1'b0}};
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= 32'h0000_0000;
            count_r     <= {(ADDR_W+1){1'b0}};
            err_r       <= 1'b0;
            wrapped_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    rdy_r <= 1'b1;
                    if (start) begin
                        ptr_r     <= base_addr;
                        count_r   <= {(ADDR_W+1){1'b0}};
                        err_r     <= 1'b0;
                        wrapped_r <= 1'b0;
                    end else if (in_valid && rdy_r) begin
                        if (enc_s[32]) begin
                            mem_addr_r  <= ptr_r;
                            mem_wdata_r <= enc_s[31:0];
                            mem_we_r    <= 1'b1;
                            rdy_r       <= 1'b0;
                            state_r     <= WRITE;
                        end else begin
                            // illegal op: handshake completes, only err changes
                            err_r <= 1'b1;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                WRITE: begin
                    if (mem_ack) begin
                        mem_we_r <= 1'b0;
                        rdy_r    <= 1'b1;
                        state_r  <= IDLE;
                        ptr_r    <= ptr_r + PTR_ONE;
                        if (ptr_r == {ADDR_W{1'b1}}) begin
                            wrapped_r <= 1'b1;
                        end else begin
                            wrapped_r <= wrapped_r;
                        end
                        if (count_r != CNT_MAX) begin
                            count_r <= count_r + CNT_ONE;
                        end else begin
                            count_r <= count_r;
                        end
                    end else begin
                        state_r <= WRITE;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    mem_we_r <= 1'b0;
                    rdy_r    <= 1'b0;
                end
            endcase
        end
    end

endmodule
